// File: rtl/vgalcd_fbfetch_if.sv
// Memory read port and pixel stream of the VGA/LCD frame-buffer fetch engine.
// master = fetch engine, slave = memory + pixel consumer.
`ifndef VGALCD_VB_WIDTH
`define VGALCD_VB_WIDTH 12
`endif

interface vgalcd_fbfetch_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [63:0]           mem_rdata_i;
    logic                  pixel_valid_o;
    logic                  pixel_ready_i;
    logic [63:0]           pixel_data_o;

    modport master (
        output mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i
    );
endinterface

// File: rtl/vgalcd_fbfetch.sv
// Frame-buffer fetch engine: linear 64-bit reads into a credit-limited FIFO feeding the pixel stream.
// Optional sticky underrun detection is built when VGALCD_FETCH_UNDERRUN_EN is defined.
`ifndef VGALCD_VB_WIDTH
`define VGALCD_VB_WIDTH 12
`endif

module vgalcd_fbfetch #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic                        test_i,
    input  logic [ADDR_WIDTH-1:0]       fbba_i,
    input  logic [`VGALCD_VB_WIDTH-1:0] hvlen_i,
    input  logic [`VGALCD_VB_WIDTH-1:0] vvlen_i,
    input  logic                        vend_i,
    vgalcd_fbfetch_if.master            bus,
    output logic                        underrun_o
);
    localparam int VBW = `VGALCD_VB_WIDTH;
    localparam int WW  = 2 * VBW;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [WW-1:0]         words_q, words_d, issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         out_q, cnt_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [63:0]           fifo_q [FIFO_DEPTH];

    logic          act, req, gnt, wr, rd, valid, reload;
    logic [WW-1:0] prod, words_calc;
    logic [WW:0]   prod3;
    logic          unused_bits;

    assign act        = en_i && !test_i;
    assign prod       = WW'(hvlen_i) * WW'(vvlen_i);
    assign prod3      = {1'b0, prod} + (WW+1)'(3);
    assign words_calc = {1'b0, prod3[WW:2]};
    assign unused_bits = ^{fbba_i[2:0], prod3[1:0]};

    // Credit counts words already buffered plus words still in flight.
    assign req   = (state_q == FETCH) && (issued_q < words_q) &&
                   (({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH));
    assign gnt   = req && bus.mem_gnt_i;
    assign wr    = bus.mem_rvalid_i && (state_q != FLUSH);
    assign valid = (cnt_q != '0) && (state_q != FLUSH);
    assign rd    = valid && bus.pixel_ready_i;

    assign bus.mem_req_o     = req;
    assign bus.mem_addr_o    = addr_q;
    assign bus.pixel_valid_o = valid;
    assign bus.pixel_data_o  = fifo_q[rptr_q];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        words_d  = words_q;
        reload   = 1'b0;
        if (gnt) begin
            addr_d   = addr_q + ADDR_WIDTH'(8);
            issued_d = issued_q + WW'(1);
        end
        case (state_q)
            IDLE:  if (act) reload = 1'b1;
            FETCH: begin
                if (!act || vend_i)                              state_d = FLUSH;
                else if (gnt && (issued_q + WW'(1) == words_q)) state_d = DONE;
            end
            DONE: begin
                if (!act) state_d = FLUSH;
                else if (vend_i) begin
                    if (out_q == '0 && cnt_q == '0) reload = 1'b1;
                    else                            state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_q == '0) begin
                    if (act) reload = 1'b1;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // An empty frame parks in DONE until the next frame end.
        if (reload) begin
            words_d  = words_calc;
            addr_d   = {fbba_i[ADDR_WIDTH-1:3], 3'b000};
            issued_d = '0;
            state_d  = (words_calc == '0) ? DONE : FETCH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            words_q  <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            issued_q <= issued_d;
            addr_q   <= addr_d;
            out_q    <= out_q + CW'(gnt) - CW'(bus.mem_rvalid_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (state_q == FLUSH) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr) begin
                fifo_q[wptr_q] <= bus.mem_rdata_i;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (rd) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(wr) - CW'(rd);
        end
    end

`ifdef VGALCD_FETCH_UNDERRUN_EN
    logic und_q, und_d;

    always_comb begin
        und_d = und_q;
        if (!act)
            und_d = 1'b0;
        else if ((((state_q == FETCH) || (state_q == DONE)) && bus.pixel_ready_i && !valid) ||
                 ((state_q == FETCH) && vend_i))
            und_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) und_q <= 1'b0;
        else          und_q <= und_d;
    end

    assign underrun_o = und_q;
`else
    assign underrun_o = 1'b0;
`endif
endmodule

// File: tb/tb_vgalcd_fbfetch.sv
// Directed bench for vgalcd_fbfetch: memory responder with a grant budget and held responses,
// pixel sink log, and a linear sequence of checked steps.
`ifndef VGALCD_VB_WIDTH
`define VGALCD_VB_WIDTH 12
`endif

module tb_vgalcd_fbfetch;
    localparam int VBW = `VGALCD_VB_WIDTH;
`ifdef VGALCD_FETCH_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    logic           clk_i, rst_n_i, en_i, test_i, vend_i, underrun_o;
    logic [31:0]    fbba_i;
    logic [VBW-1:0] hvlen_i, vvlen_i;

    vgalcd_fbfetch_if #(.ADDR_WIDTH(32)) bus ();

    vgalcd_fbfetch #(.FIFO_DEPTH(16), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .test_i(test_i),
        .fbba_i(fbba_i), .hvlen_i(hvlen_i), .vvlen_i(vvlen_i), .vend_i(vend_i),
        .bus(bus), .underrun_o(underrun_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          gnt_budget = 1000000;
    logic        rsp_en = 1'b1;
    logic [31:0] pend[$];
    logic [31:0] granted[$];
    logic [63:0] popped[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] f(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // Memory: decides grant/response at the negedge ahead of the posedge that samples them.
    always @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend.delete();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
        end else begin
            bus.mem_rvalid_i = 1'b0;
            if (rsp_en && pend.size() > 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = f(pend.pop_front());
            end
            bus.mem_gnt_i = (gnt_budget > 0);
            if (bus.mem_req_o && bus.mem_gnt_i) begin
                pend.push_back(bus.mem_addr_o);
                granted.push_back(bus.mem_addr_o);
                gnt_budget--;
            end
        end
    end

    always @(negedge clk_i) begin
        #1;
        if (rst_n_i && bus.pixel_valid_o && bus.pixel_ready_i) popped.push_back(bus.pixel_data_o);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_n_i = 1'b0; en_i = 1'b1; test_i = 1'b1; vend_i = 1'b0;
        fbba_i = 32'h1000; hvlen_i = VBW'(8); vvlen_i = VBW'(2);
        bus.pixel_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rst_req",   64'(bus.mem_req_o),     64'(0));
        chk("rst_addr",  64'(bus.mem_addr_o),    64'(0));
        chk("rst_valid", 64'(bus.pixel_valid_o), 64'(0));
        chk("rst_data",  bus.pixel_data_o,       64'(0));
        chk("rst_ur",    64'(underrun_o),        64'(0));

        // Test mode at reset release suppresses fetching
        rst_n_i = 1'b1;
        cyc(3);
        chk("test_hold_req", 64'(bus.mem_req_o), 64'(0));
        granted.delete(); popped.delete();
        test_i = 1'b0;
        cyc(1);
        chk("first_req",  64'(bus.mem_req_o),  64'(1));
        chk("first_addr", 64'(bus.mem_addr_o), 64'(32'h1000));
        cyc(10);
        chk("f1_grants", 64'(granted.size()), 64'(4));
        chk("f1_pops",   64'(popped.size()),  64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("f1_addr", 64'(granted[i]), 64'(32'h1000 + 8 * i));
            chk("f1_data", popped[i], f(32'h1000 + 8 * i));
        end
        chk("f1_done_req",   64'(bus.mem_req_o),     64'(0));
        chk("f1_done_valid", 64'(bus.pixel_valid_o), 64'(0));

        // Frame end re-arms; consumer stalled -> exactly FIFO_DEPTH grants
        bus.pixel_ready_i = 1'b0; hvlen_i = VBW'(320); vvlen_i = VBW'(240); fbba_i = 32'h2000;
        granted.delete(); popped.delete();
        vend_i = 1'b1; cyc(1); vend_i = 1'b0;
        cyc(30);
        chk("credit_grants", 64'(granted.size()),   64'(16));
        chk("credit_req",    64'(bus.mem_req_o),    64'(0));
        chk("credit_valid",  64'(bus.pixel_valid_o), 64'(1));
        chk("credit_head",   bus.pixel_data_o,      f(32'h2000));
        bus.pixel_ready_i = 1'b1; cyc(1); bus.pixel_ready_i = 1'b0;
        cyc(8);
        chk("pop_grants", 64'(granted.size()), 64'(17));
        chk("pop_addr",   64'(granted[16]),    64'(32'h2080));
        chk("pop_cnt",    64'(popped.size()),  64'(1));
        chk("pop_data",   popped[0],           f(32'h2000));
        chk("pop_next",   bus.pixel_data_o,    f(32'h2008));

        // vend mid-fetch: flush, restart at base
        gnt_budget = 0; fbba_i = 32'h3000;
        vend_i = 1'b1; cyc(1); vend_i = 1'b0;
        chk("vend_flush_req",   64'(bus.mem_req_o),     64'(0));
        chk("vend_flush_valid", 64'(bus.pixel_valid_o), 64'(0));
        cyc(1);
        chk("refetch_req",  64'(bus.mem_req_o),  64'(1));
        chk("refetch_addr", 64'(bus.mem_addr_o), 64'(32'h3000));
        granted.delete(); popped.delete();
        rsp_en = 1'b0; bus.pixel_ready_i = 1'b1; gnt_budget = 3;
        cyc(6);
        chk("hold_grants", 64'(granted.size()),     64'(3));
        chk("hold_addr2",  64'(granted[2]),         64'(32'h3010));
        chk("hold_req",    64'(bus.mem_req_o),      64'(1));
        chk("hold_addr",   64'(bus.mem_addr_o),     64'(32'h3018));
        chk("hold_valid",  64'(bus.pixel_valid_o),  64'(0));
        fbba_i = 32'h4000;
        vend_i = 1'b1; cyc(1); vend_i = 1'b0;
        chk("ur_flush_req",   64'(bus.mem_req_o),     64'(0));
        chk("ur_flush_valid", 64'(bus.pixel_valid_o), 64'(0));
        chk("ur_flag",        64'(underrun_o),        64'(UR_EXP));
        granted.delete(); popped.delete();
        rsp_en = 1'b1; gnt_budget = 1000000;
        cyc(10);
        chk("restart_addr", 64'(granted[0]),              64'(32'h4000));
        chk("restart_pop",  64'(popped.size() != 0),      64'(1));
        chk("discard_head", popped[0],                    f(32'h4000));

        // Disable with two outstanding
        en_i = 1'b0; cyc(6);
        chk("dis_req",   64'(bus.mem_req_o),     64'(0));
        chk("dis_valid", 64'(bus.pixel_valid_o), 64'(0));
        chk("dis_ur",    64'(underrun_o),        64'(0));
        gnt_budget = 2; rsp_en = 1'b0; fbba_i = 32'h5000;
        granted.delete(); popped.delete();
        en_i = 1'b1; cyc(1);
        chk("en_req",  64'(bus.mem_req_o),  64'(1));
        chk("en_addr", 64'(bus.mem_addr_o), 64'(32'h5000));
        cyc(5);
        chk("en2_grants", 64'(granted.size()),  64'(2));
        chk("en2_addr",   64'(bus.mem_addr_o),  64'(32'h5010));
        en_i = 1'b0; cyc(1);
        chk("dis2_req", 64'(bus.mem_req_o), 64'(0));
        cyc(3);
        chk("dis2_grants", 64'(granted.size()), 64'(2));
        rsp_en = 1'b1; cyc(4);
        chk("dis2_discard", 64'(popped.size()), 64'(0));
        gnt_budget = 1000000; granted.delete();
        en_i = 1'b1; cyc(1);
        chk("reen_req",  64'(bus.mem_req_o),  64'(1));
        chk("reen_addr", 64'(bus.mem_addr_o), 64'(32'h5000));

        // Empty frame issues nothing
        en_i = 1'b0; cyc(6);
        hvlen_i = VBW'(0); granted.delete();
        en_i = 1'b1; cyc(6);
        chk("zero_req",    64'(bus.mem_req_o),  64'(0));
        chk("zero_grants", 64'(granted.size()), 64'(0));
        vend_i = 1'b1; cyc(1); vend_i = 1'b0; cyc(3);
        chk("zero_vend_req", 64'(bus.mem_req_o), 64'(0));

        // Re-arm from DONE, then asynchronous reset mid-transaction
        hvlen_i = VBW'(8); fbba_i = 32'h6000;
        vend_i = 1'b1; cyc(1); vend_i = 1'b0;
        chk("rearm_req",  64'(bus.mem_req_o),  64'(1));
        chk("rearm_addr", 64'(bus.mem_addr_o), 64'(32'h6000));
        cyc(2);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_req",   64'(bus.mem_req_o),     64'(0));
        chk("arst_addr",  64'(bus.mem_addr_o),    64'(0));
        chk("arst_valid", 64'(bus.pixel_valid_o), 64'(0));
        chk("arst_data",  bus.pixel_data_o,       64'(0));
        #2 rst_n_i = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
